rca_arb: RTL
============

# rca_arb

Round-robin arbiter that shares one n-bit ripple-carry adder among four requesters. Each requester presents operands and a carry-in under a level request. The arbiter picks one request per cycle, performs the add, and holds the result in an output register until the consumer drains it through a valid/ready handshake. It sits between several lab datapath units that each need an occasional add and the single adder instance.

## Interface
- n, default 8: operand and sum width, legal range 1..32.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  per-requester request level; held high until that requester's ack.
- a_bus  in  4*n  operand a; requester i at bits [i*n +: n].
- b_bus  in  4*n  operand b; same packing.
- cin_bus  in  4  carry-in; bit i belongs to requester i.
- ack  out  4  one-hot, combinational; bit i high in the cycle requester i's operands are captured.
- res_ready  in  1  consumer accepts the result this cycle.
- res_valid  out  1  output register holds an undelivered result.
- res_id  out  2  index of the requester that owns the result.
- res_sum  out  n  low n bits of a+b+cin.
- res_co  out  1  carry-out (bit n) of a+b+cin.

## Operation
- State: one output register {res_valid, res_id, res_co, res_sum} and a 2-bit round-robin pointer ptr.
- Reset values: res_valid=0, res_id=0, res_sum=0, res_co=0, ptr=0. ack=0 while rst_n=0.
- accept = (|req) && (!res_valid || res_ready).
- Winner selection:
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first index with req set wins.
  - ack = one-hot of the winner when accept=1, else 0. At most one ack bit is ever high.
- On a clock edge with accept=1:
  - Capture {co,sum} = a_i + b_i + cin_i. The add is (n+1)-bit, zero-extended, and exact.
  - Load res_id=winner and set res_valid=1.
  - Set ptr = winner+1 mod 4. Index 3 wraps to 0.
- On a clock edge with res_valid && res_ready && !accept: res_valid=0. The other output fields keep their last values.
- When res_valid=1 and res_ready=0: every output field is frozen, ack=0, and ptr does not move.
- Simultaneous drain and accept (res_valid && res_ready && |req): the new result replaces the old one in the same edge, with no bubble and res_valid staying 1.
- Idle (req=0): ptr holds and no state changes except a drain.
- Operand buses are sampled only in the accept cycle. Changes at any other time have no effect.
- A requester whose req falls before its ack is simply dropped. No state is kept per requester.
- Reset mid-operation: an undelivered result is discarded and ptr returns to 0.

## Timing
- Latency: request seen in cycle t with the output free gives ack in cycle t and res_valid at the edge ending t, visible in cycle t+1.
- Throughput: one result per cycle while res_ready=1 and requests are pending.
- Fairness: with all four req held, grants rotate 0,1,2,3,0,… Each requester waits at most 3 accepted transactions.
- ack is a combinational function of req, res_valid, res_ready and ptr. It has no dependency on the operand buses.
- Reset takes effect without a clock edge. The first accept can happen on the first rising edge after rst_n deasserts.

## Test plan
- Basic add, n=8: req=0001, a0=0x0F, b0=0x01, cin0=0, res_ready=1 -> ack=0001 in the same cycle; next cycle res_valid=1, res_id=0, res_sum=0x10, res_co=0.
- Carry/wrap: requester 2 with a=0xFF, b=0x01, cin=1 -> res_id=2, res_sum=0x01, res_co=1. Also a=0xFF, b=0xFF, cin=1 -> res_sum=0xFF, res_co=1.
- Round-robin: req=1111 held, res_ready=1 for 8 cycles -> ack sequence 0001,0010,0100,1000,0001,… and res_id follows 0,1,2,3,0 one cycle later.
- Backpressure: hold res_valid=1 with res_ready=0 and req=0100 -> ack=0000 and outputs stable for 5 cycles. Then raise res_ready -> ack=0100 in the same cycle and the new result appears next cycle with res_valid never dropping.
- Pointer skip: after a grant to 1 (ptr=2), apply req=0011 -> winner 0, since 2 and 3 are idle and the search wraps. Then ptr=1, so with req=0011 next -> winner 1.
- Async reset: pulse rst_n low mid-cycle while res_valid=1 and ptr=3 -> res_valid, res_sum, res_co and res_id go to 0 immediately. After release, req=1010 -> first grant goes to 1.

Source files
------------

// File: rtl/rca_arb.sv
// rca_arb: round-robin arbiter sharing one n-bit ripple-carry adder among
// four requesters. The winning requester's operands are added in the cycle
// it is acknowledged. The result is held in an output register until the
// consumer takes it through a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request levels, held until acknowledged
//   a_bus      operand a, requester i at [i*n +: n]
//   b_bus      operand b, same packing
//   cin_bus    carry-in, bit i for requester i
//   ack[3:0]   one-hot grant (combinational), high in the capture cycle
//   res_ready  consumer accepts the result this cycle
//   res_valid  output register holds an undelivered result
//   res_id     index of the requester owning the result
//   res_sum    low n bits of a+b+cin
//   res_co     carry-out of a+b+cin
module rca_arb #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*n-1:0] a_bus,
    input  logic [4*n-1:0] b_bus,
    input  logic [3:0]     cin_bus,
    output logic [3:0]     ack,
    input  logic           res_ready,
    output logic           res_valid,
    output logic [1:0]     res_id,
    output logic [n-1:0]   res_sum,
    output logic           res_co
);

    logic           res_valid_reg;
    logic [1:0]     res_id_reg;
    logic [n-1:0]   res_sum_reg;
    logic           res_co_reg;
    logic [1:0]     ptr_reg;

    logic           accept;
    logic [1:0]     win_idx;
    logic [1:0]     cand_idx [4];
    logic [3:0]     hit;
    logic [1:0]     ptr_next;

    logic [n-1:0]   op_a;
    logic [n-1:0]   op_b;
    logic           op_cin;
    logic [n:0]     carry;
    logic [n-1:0]   sum_next;

    // Candidate k is the requester k places after the pointer; 2-bit
    // arithmetic provides the mod-4 wrap for free.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = ptr_reg + 2'(gi);
            assign hit[gi]      = req[cand_idx[gi]];
        end
    endgenerate

    // First hit in search order wins.
    always_comb begin
        win_idx = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    // The output register is free when empty or being drained this cycle.
    // Gating with rst_n keeps ack low for the whole reset assertion.
    assign accept   = rst_n && (|req) && (!res_valid_reg || res_ready);
    assign ack      = accept ? (4'b0001 << win_idx) : 4'b0000;
    assign ptr_next = win_idx + 2'd1;

    // Operand mux driven only by the winner index.
    assign op_a   = a_bus[win_idx*n +: n];
    assign op_b   = b_bus[win_idx*n +: n];
    assign op_cin = cin_bus[win_idx];

    // Ripple-carry adder: one full adder per bit, carry chained upward.
    assign carry[0] = op_cin;
    generate
        for (gi = 0; gi < n; gi++) begin : g_fa
            assign sum_next[gi]  = op_a[gi] ^ op_b[gi] ^ carry[gi];
            assign carry[gi+1]   = (op_a[gi] & op_b[gi]) |
                                   (carry[gi] & (op_a[gi] ^ op_b[gi]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_id_reg    <= 2'd0;
            res_sum_reg   <= '0;
            res_co_reg    <= 1'b0;
            ptr_reg       <= 2'd0;
        end else if (accept) begin
            // A new result replaces a draining one with no bubble.
            res_valid_reg <= 1'b1;
            res_id_reg    <= win_idx;
            res_sum_reg   <= sum_next;
            res_co_reg    <= carry[n];
            ptr_reg       <= ptr_next;
        end else if (res_valid_reg && res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign res_valid = res_valid_reg;
    assign res_id    = res_id_reg;
    assign res_sum   = res_sum_reg;
    assign res_co    = res_co_reg;

endmodule
